// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, DMA and downstream dcache signals around the data-memory port arbiter.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_din;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic [31:0] dma_addr;
  logic [3:0]  dma_we;
  logic        dma_re;
  logic [31:0] dma_din;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_stall;

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_re, cpu_din,
    input  dma_req, dma_addr, dma_we, dma_re, dma_din,
    input  mem_dout, mem_stall,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_we, mem_re, mem_din
  );

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_re, cpu_din,
    output dma_req, dma_addr, dma_we, dma_re, dma_din,
    output mem_dout, mem_stall,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_we, mem_re, mem_din
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single dcache port with stall lock,
// DMA anti-starvation and routing of the one-cycle-late read response.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT_C   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX_C = 4'd15;

  owner_e      owner_r;
  owner_e      rd_owner_r;
  owner_e      arb_s;
  owner_e      cur_s;
  logic        acc_last_r;
  logic        rd_pend_r;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_nxt_s;
  logic        accept_s;
  logic        rsp_s;
  logic        cpu_rvalid_s;
  logic        dma_rvalid_s;
  logic [31:0] cpu_rdata_s;
  logic [31:0] dma_rdata_s;
  logic [31:0] mem_addr_s;
  logic [3:0]  mem_we_s;
  logic        mem_re_s;
  logic [31:0] mem_din_s;

  // Priority pick: CPU first unless the waiting DMA has been passed over too often
  always_comb begin
    arb_s = OWN_IDLE;
    if (bus.cpu_req && !(bus.dma_req && (starve_cnt_r >= LIMIT_C))) begin
      arb_s = OWN_CPU;
    end else if (bus.dma_req) begin
      arb_s = OWN_DMA;
    end else begin
      arb_s = OWN_IDLE;
    end
  end

  // A stalled owner keeps the port; otherwise the port is re-arbitrated every cycle
  always_comb begin
    cur_s = OWN_IDLE;
    if (!rst) begin
      cur_s = OWN_IDLE;
    end else if ((owner_r == OWN_IDLE) || acc_last_r) begin
      cur_s = arb_s;
    end else begin
      cur_s = owner_r;
    end
  end

  assign accept_s = (cur_s != OWN_IDLE) && !bus.mem_stall;

  // Downstream mux of the granted requester's payload, zero when nobody owns the port
  always_comb begin
    mem_addr_s = 32'd0;
    mem_we_s   = 4'd0;
    mem_re_s   = 1'b0;
    mem_din_s  = 32'd0;
    case (cur_s)
      OWN_CPU: begin
        mem_addr_s = bus.cpu_addr;
        mem_we_s   = bus.cpu_we;
        mem_re_s   = bus.cpu_re;
        mem_din_s  = bus.cpu_din;
      end
      OWN_DMA: begin
        mem_addr_s = bus.dma_addr;
        mem_we_s   = bus.dma_we;
        mem_re_s   = bus.dma_re;
        mem_din_s  = bus.dma_din;
      end
      default: begin
        mem_addr_s = 32'd0;
        mem_we_s   = 4'd0;
        mem_re_s   = 1'b0;
        mem_din_s  = 32'd0;
      end
    endcase
  end

  // Read data comes back in the first unstalled cycle after the read was accepted
  assign rsp_s        = rst && rd_pend_r && !bus.mem_stall;
  assign cpu_rvalid_s = rsp_s && (rd_owner_r == OWN_CPU);
  assign dma_rvalid_s = rsp_s && (rd_owner_r == OWN_DMA);

  // Steer mem_dout only to the requester that owns the outstanding read
  always_comb begin
    cpu_rdata_s = 32'd0;
    dma_rdata_s = 32'd0;
    if (cpu_rvalid_s) begin
      cpu_rdata_s = bus.mem_dout;
    end else begin
      cpu_rdata_s = 32'd0;
    end
    if (dma_rvalid_s) begin
      dma_rdata_s = bus.mem_dout;
    end else begin
      dma_rdata_s = 32'd0;
    end
  end

  // Count CPU wins while DMA waits; any DMA win or idle DMA clears it
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (!bus.dma_req) begin
      starve_nxt_s = 4'd0;
    end else if (accept_s && (cur_s == OWN_DMA)) begin
      starve_nxt_s = 4'd0;
    end else if (accept_s && (cur_s == OWN_CPU) && (starve_cnt_r != CNT_MAX_C)) begin
      starve_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Owner, acceptance, starvation and pending-read state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r      <= OWN_IDLE;
      acc_last_r   <= 1'b0;
      starve_cnt_r <= 4'd0;
      rd_pend_r    <= 1'b0;
      rd_owner_r   <= OWN_CPU;
    end else begin
      owner_r      <= cur_s;
      acc_last_r   <= accept_s;
      starve_cnt_r <= starve_nxt_s;
      if (accept_s && mem_re_s) begin
        rd_pend_r  <= 1'b1;
        rd_owner_r <= cur_s;
      end else if (!bus.mem_stall) begin
        rd_pend_r  <= 1'b0;
      end else begin
        rd_pend_r  <= rd_pend_r;
      end
    end
  end

  assign bus.cpu_gnt    = (cur_s == OWN_CPU);
  assign bus.dma_gnt    = (cur_s == OWN_DMA);
  assign bus.cpu_rvalid = cpu_rvalid_s;
  assign bus.dma_rvalid = dma_rvalid_s;
  assign bus.cpu_rdata  = cpu_rdata_s;
  assign bus.dma_rdata  = dma_rdata_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_re     = mem_re_s;
  assign bus.mem_din    = mem_din_s;

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4 (range 1..15): max consecutive CPU acceptances while DMA waits.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have ports cpu_req / dma_req  input  1  request pending.
REQ-005 SHALL have ports cpu_addr / dma_addr  input  32  byte address.
REQ-006 SHALL have ports cpu_we / dma_we  input  4  byte write enables.
REQ-007 SHALL have ports cpu_re / dma_re  input  1  read request.
REQ-008 SHALL have ports cpu_din / dma_din  input  32  write data.
REQ-009 SHALL have ports cpu_gnt / dma_gnt  output  1  request owns the port this cycle.
REQ-010 SHALL have ports cpu_rvalid / dma_rvalid  output  1  read data valid.
REQ-011 SHALL have ports cpu_rdata / dma_rdata  output  32  read data.
REQ-012 SHALL have ports mem_addr (32), mem_we (4), mem_re (1) and mem_din (32)  output  downstream dcache port.
REQ-013 SHALL have ports mem_dout  input  32  and mem_stall  input  1  from the dcache.

Function
REQ-014 Owner register SHALL hold one of IDLE, CPU or DMA.
REQ-015 Acceptance SHALL occur in any cycle where gnt=1 and mem_stall=0.
REQ-016 A requester SHALL hold req/addr/we/re/din stable until accepted; the arbiter does not latch the request payload.
REQ-017 When mem_stall=0 and the owner is IDLE, or the owner's request was accepted last cycle, the arbiter SHALL re-arbitrate combinationally:
- CPU wins, unless dma_req=1 and starve_cnt>=STARVE_LIMIT;
- otherwise DMA wins if requesting;
- otherwise IDLE.
REQ-018 When mem_stall=1, the owner SHALL be frozen, its gnt SHALL stay high, and mem_* SHALL follow the owner's inputs.
REQ-019 At most one gnt SHALL be high per cycle.
REQ-020 With no grant, mem_we SHALL be 0, mem_re SHALL be 0, and mem_addr and mem_din SHALL be 0.
REQ-021 mem_* SHALL be a combinational mux of the granted requester's inputs.
REQ-022 starve_cnt (4 bits) SHALL behave as follows:
- +1 on each CPU acceptance while dma_req=1, saturating at 15;
- cleared on DMA acceptance or in any cycle with dma_req=0.
REQ-023 On acceptance with re=1, the arbiter SHALL set rd_pend=1 and rd_owner=owner.
REQ-024 In the first subsequent cycle with mem_stall=0, the arbiter SHALL:
- pulse rd_owner's rvalid for exactly one cycle, with rdata=mem_dout;
- clear rd_pend, unless a new read is accepted in that same cycle (back-to-back reads).
REQ-025 While rd_pend=1 and mem_stall=1, rvalid SHALL stay 0.
REQ-026 rdata of the non-selected requester SHALL be 0.
REQ-027 A request with both we≠0 and re=1 SHALL be forwarded unchanged, with one read response.
REQ-028 Simultaneous cpu_req and dma_req with starve_cnt<STARVE_LIMIT SHALL grant CPU.
REQ-029 Lowering req before acceptance is illegal; behaviour is undefined but the arbiter SHALL never issue two grants.

Reset
REQ-030 While rst=0:
- owner=IDLE, starve_cnt=0, rd_pend=0, rd_owner=CPU;
- all gnt, rvalid, rdata and mem_* outputs are 0, independent of clk.
REQ-031 Reset mid-transaction SHALL drop any pending read response; no rvalid SHALL follow deassertion unless a new read is accepted.
REQ-032 The first arbitration SHALL occur on the first rising clk edge after rst returns to 1.

Verification
REQ-033 CPU-only: cpu_req=1, cpu_re=1, cpu_addr=0x1000_0010, mem_stall=0 -> cpu_gnt=1 and mem_re=1 same cycle; next cycle cpu_rvalid=1 with cpu_rdata=mem_dout.
REQ-034 Stall lock: DMA write accepted-pending, mem_stall=1 for 3 cycles, cpu_req raised -> dma_gnt=1 for all 3 cycles, mem_addr stable, cpu_gnt=0; CPU granted on the cycle after the DMA acceptance.
REQ-035 Starvation: both requesting continuously, STARVE_LIMIT=4 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU...; starve_cnt returns to 0 after the DMA acceptance.
REQ-036 Delayed read data: CPU read accepted, then mem_stall=1 for 2 cycles -> cpu_rvalid=0 during the stall, then 1 for exactly one cycle when mem_stall falls.
REQ-037 Back-to-back reads: CPU read then DMA read on consecutive cycles -> cpu_rvalid then dma_rvalid on consecutive cycles, each with the matching mem_dout.
REQ-038 Async reset: rst driven to 0 between clock edges while rd_pend=1 -> all outputs 0 immediately; no rvalid after release.
